// File: rtl/ofs_plat_prim_ram_pkg.sv
// Shared types and helpers for the byte-enabled multi-read-port RAM primitive:
// init FSM states and a width-generic per-byte merge.
package ofs_plat_prim_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } init_state_e;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MAX_DATA_BITS = 1024;
  localparam int unsigned MAX_IDX_BITS  = $clog2(MAX_DATA_BITS);

  typedef logic [MAX_DATA_BITS-1:0] wide_data_t;
  typedef logic [MAX_DATA_BITS-1:0] wide_be_t;

  // Take each bit from new_data when its byte enable is set, else keep old_data.
  function automatic wide_data_t byte_merge(input wide_data_t  old_data,
                                            input wide_data_t  new_data,
                                            input wide_be_t    be,
                                            input int unsigned byte_bits);
    wide_data_t merged;
    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
      merged[MAX_IDX_BITS'(i)] = be[MAX_IDX_BITS'(i / byte_bits)] ?
                                 new_data[MAX_IDX_BITS'(i)] : old_data[MAX_IDX_BITS'(i)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_ram_mrport_be_if.sv
// Bus between a RAM user (master) and the multi-read-port byte-enabled RAM (slave).
interface ofs_plat_prim_ram_mrport_be_if #(
  parameter int N_ENTRIES    = 32,
  parameter int N_DATA_BITS  = 64,
  parameter int N_BYTE_BITS  = 8,
  parameter int N_READ_PORTS = 2
);
  localparam int ADDR_BITS = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int N_BE      = N_DATA_BITS / N_BYTE_BITS;

  logic                                    rdy;
  logic                                    wen;
  logic [ADDR_BITS-1:0]                    waddr;
  logic [N_DATA_BITS-1:0]                  wdata;
  logic [N_BE-1:0]                         wbe;
  logic [N_READ_PORTS-1:0]                 ren;
  logic [N_READ_PORTS-1:0][ADDR_BITS-1:0]  raddr;
  logic [N_READ_PORTS-1:0]                 rvalid;
  logic [N_READ_PORTS-1:0][N_DATA_BITS-1:0] rdata;

  modport master (
    input  rdy, rvalid, rdata,
    output wen, waddr, wdata, wbe, ren, raddr
  );

  modport slave (
    output rdy, rvalid, rdata,
    input  wen, waddr, wdata, wbe, ren, raddr
  );

endinterface

// File: rtl/ofs_plat_prim_ram_be_rd_pipe.sv
// One write-replicated RAM bank plus the read pipeline of a single read port,
// with optional merging of in-flight writes into pending reads.
module ofs_plat_prim_ram_be_rd_pipe
  import ofs_plat_prim_ram_pkg::*;
#(
  parameter int N_ENTRIES    = 32,
  parameter int N_DATA_BITS  = 64,
  parameter int N_BYTE_BITS  = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  parameter int ADDR_BITS    = 5,
  parameter int N_BE         = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [N_DATA_BITS-1:0] wdata,
  input  logic [N_BE-1:0]        wbe,
  input  logic                   ren,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic                   rvalid,
  output logic [N_DATA_BITS-1:0] rdata
);

  typedef logic [N_DATA_BITS-1:0] data_t;
  typedef logic [ADDR_BITS-1:0]   addr_t;
  typedef logic [N_BE-1:0]        be_t;

  data_t                   mem [N_ENTRIES];
  logic [READ_LATENCY-1:0] vld_q;
  addr_t                   addr_q [READ_LATENCY];
  data_t                   data_q [READ_LATENCY];
  data_t                   data_d [READ_LATENCY];

  function automatic data_t merge(input data_t old_data, input data_t new_data, input be_t be);
    return N_DATA_BITS'(byte_merge(wide_data_t'(old_data), wide_data_t'(new_data),
                                   wide_be_t'(be), N_BYTE_BITS));
  endfunction

  // NOTE: storage has no reset; the init FSM in the top fills every entry instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merge(mem[waddr], wdata, wbe);
  end

  // Stage 0 sees the array before this cycle's write; every stage folds in the
  // write of the cycle it is passing through, so newer writes win per byte.
  always_comb begin
    // NOTE: every element gets a value before any conditional update, so no latch.
    data_d[0] = mem[raddr];
    if ((BYPASS != 0) && we && (waddr == raddr)) data_d[0] = merge(mem[raddr], wdata, wbe);
    for (int k = 1; k < READ_LATENCY; k++) begin
      data_d[k] = data_q[k-1];
      if ((BYPASS != 0) && we && (waddr == addr_q[k-1])) data_d[k] = merge(data_q[k-1], wdata, wbe);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= ren;
      for (int k = 1; k < READ_LATENCY; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignment so stages shift, not ripple.
  always_ff @(posedge clk) begin
    addr_q[0] <= raddr;
    for (int k = 1; k < READ_LATENCY; k++) addr_q[k] <= addr_q[k-1];
    for (int k = 0; k < READ_LATENCY; k++) data_q[k] <= data_d[k];
  end

  assign rvalid = vld_q[READ_LATENCY-1];
  assign rdata  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/ofs_plat_prim_ram_mrport_be.sv
// Multi-read-port, byte-enabled RAM with configurable read latency, write bypass
// and self-initialisation; each read port owns a write-replicated bank.
module ofs_plat_prim_ram_mrport_be
  import ofs_plat_prim_ram_pkg::*;
#(
  parameter int                     N_ENTRIES    = 32,
  parameter int                     N_DATA_BITS  = 64,
  parameter int                     N_BYTE_BITS  = 8,
  parameter int                     N_READ_PORTS = 2,
  parameter int                     READ_LATENCY = 1,
  parameter int                     BYPASS       = 1,
  parameter logic [N_DATA_BITS-1:0] INIT_VALUE   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  ofs_plat_prim_ram_mrport_be_if.slave  ram
);

  localparam int ADDR_BITS = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int N_BE      = N_DATA_BITS / N_BYTE_BITS;

  typedef logic [ADDR_BITS-1:0]   addr_t;
  typedef logic [N_DATA_BITS-1:0] data_t;
  typedef logic [N_BE-1:0]        be_t;

  if (N_DATA_BITS % N_BYTE_BITS != 0) begin : g_bad_byte_bits
    $error("N_DATA_BITS must be a multiple of N_BYTE_BITS");
  end
  if (N_READ_PORTS < 1 || N_READ_PORTS > 8) begin : g_bad_read_ports
    $error("N_READ_PORTS must be 1..8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be 1..4");
  end

  init_state_e state_q;
  addr_t       init_addr_q;
  logic        rdy_q;

  logic        wr_en;
  addr_t       wr_addr;
  data_t       wr_data;
  be_t         wr_be;
  logic        waddr_ok;

  logic [N_READ_PORTS-1:0]              rvalid;
  logic [N_READ_PORTS-1:0][N_DATA_BITS-1:0] rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == ADDR_BITS'(N_ENTRIES - 1)) begin
            state_q <= ST_READY;
            rdy_q   <= 1'b1;
          end
        end
        ST_READY: ;
      endcase
    end
  end

  assign waddr_ok = ({1'b0, ram.waddr} < (ADDR_BITS + 1)'(N_ENTRIES));

  // Single write stream fanned out to all banks: init fill, then user writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ram.waddr;
    wr_data = ram.wdata;
    wr_be   = ram.wbe;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = init_addr_q;
      wr_data = INIT_VALUE;
      wr_be   = '1;
    end else begin
      wr_en = ram.wen && waddr_ok && (|ram.wbe);
    end
  end

  for (genvar p = 0; p < N_READ_PORTS; p++) begin : g_rd
    ofs_plat_prim_ram_be_rd_pipe #(
      .N_ENTRIES    (N_ENTRIES),
      .N_DATA_BITS  (N_DATA_BITS),
      .N_BYTE_BITS  (N_BYTE_BITS),
      .READ_LATENCY (READ_LATENCY),
      .BYPASS       (BYPASS),
      .ADDR_BITS    (ADDR_BITS),
      .N_BE         (N_BE)
    ) u_rd_pipe (
      .clk    (clk),
      .reset  (reset),
      .we     (wr_en),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .wbe    (wr_be),
      .ren    (ram.ren[p] & rdy_q),
      .raddr  (ram.raddr[p]),
      .rvalid (rvalid[p]),
      .rdata  (rdata[p])
    );
  end

  assign ram.rdy    = rdy_q;
  assign ram.rvalid = rvalid;
  assign ram.rdata  = rdata;

endmodule

// File: tb/tb_ofs_plat_prim_ram_mrport_be.sv
// Randomised and directed bench for ofs_plat_prim_ram_mrport_be against a
// cycle-indexed reference model of memory contents and pending reads.
module tb_ofs_plat_prim_ram_mrport_be;

  localparam int          NE   = 16;
  localparam int          RL   = 2;
  localparam int          BYP  = 1;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  ofs_plat_prim_ram_mrport_be_if #(
    .N_ENTRIES(NE), .N_DATA_BITS(32), .N_BYTE_BITS(8), .N_READ_PORTS(2)
  ) ram_if ();

  ofs_plat_prim_ram_mrport_be #(
    .N_ENTRIES(NE), .N_DATA_BITS(32), .N_BYTE_BITS(8), .N_READ_PORTS(2),
    .READ_LATENCY(RL), .BYPASS(BYP), .INIT_VALUE(INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ram   (ram_if)
  );

  typedef struct {
    int          port;
    int          due;
    logic [3:0]  addr;
    logic [31:0] data;
  } rd_t;

  int          total = 0;
  int          bad   = 0;
  int          k     = 0;  // cycle number since reset release, first cycle = 1
  logic [31:0] model_mem [NE];
  rd_t         pend [$];
  logic [31:0] samp_rdata [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_d, input logic [31:0] new_d,
                                              input logic [3:0] be);
    logic [31:0] r = old_d;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

  // Called at a falling edge: check this cycle's outputs, drive this cycle's
  // inputs, advance the model, then move to the next falling edge.
  task automatic cycle(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] wb, input logic [1:0] re,
                       input logic [3:0] ra0, input logic [3:0] ra1);
    logic        exp_v;
    logic [31:0] exp_d;
    logic [3:0]  ra [2];
    rd_t         r;
    ra[0] = ra0;
    ra[1] = ra1;
    for (int p = 0; p < 2; p++) begin
      exp_v = 1'b0;
      exp_d = '0;
      foreach (pend[i]) if (pend[i].port == p && pend[i].due == k) begin
        exp_v = 1'b1;
        exp_d = pend[i].data;
      end
      samp_rdata[p] = ram_if.rdata[p];
      check($sformatf("rvalid%0d", p), 64'(ram_if.rvalid[p]), 64'(exp_v));
      if (exp_v) check($sformatf("rdata%0d", p), 64'(ram_if.rdata[p]), 64'(exp_d));
    end
    check("rdy", 64'(ram_if.rdy), 64'(k > NE));
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due <= k) pend.delete(i);

    ram_if.wen      = w;
    ram_if.waddr    = wa;
    ram_if.wdata    = wd;
    ram_if.wbe      = wb;
    ram_if.ren      = re;
    ram_if.raddr[0] = ra0;
    ram_if.raddr[1] = ra1;

    if (k > NE) begin
      for (int p = 0; p < 2; p++) if (re[p]) begin
        r.port = p;
        r.due  = k + RL;
        r.addr = ra[p];
        r.data = model_mem[ra[p]];
        pend.push_back(r);
      end
      if (w && wb != 4'b0000) begin
        if (BYP != 0)
          foreach (pend[i]) if (pend[i].addr == wa) pend[i].data = merge_bytes(pend[i].data, wd, wb);
        model_mem[wa] = merge_bytes(model_mem[wa], wd, wb);
      end
    end
    @(negedge clk);
    k++;
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ram_if.wen = 1'b0;
    ram_if.ren = 2'b00;
    #1;
    check("rst_rvalid", 64'(ram_if.rvalid), 64'(2'b00));
    check("rst_rdy", 64'(ram_if.rdy), 64'(1'b0));
    pend.delete();
    @(negedge clk);
    reset = 1'b0;
    k = 1;
    for (int i = 0; i < NE; i++) model_mem[i] = INIT;
  endtask

  task automatic run_init();
    for (int i = 0; i < NE; i++) cycle(1'b1, 4'($urandom), $urandom, 4'hF, 2'b11, 4'($urandom), 4'($urandom));
  endtask

  initial begin
    ram_if.wen   = 1'b0;
    ram_if.waddr = '0;
    ram_if.wdata = '0;
    ram_if.wbe   = '0;
    ram_if.ren   = '0;
    ram_if.raddr = '0;
    @(negedge clk);
    do_reset();

    // Init: user reads and writes are ignored, rdy rises in cycle NE+1.
    run_init();
    for (int i = 0; i < NE; i++) cycle(1'b0, 4'h0, 32'h0, 4'h0, 2'b11, 4'(i), 4'(NE - 1 - i));
    idle(); idle();

    // Partial byte write.
    cycle(1'b1, 4'd3, 32'h11223344, 4'b0101, 2'b00, 4'h0, 4'h0);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 2'b01, 4'd3, 4'h0);
    idle(); idle();
    check("byte_merge", 64'(samp_rdata[0]), 64'(32'hA522A544));

    // Write one cycle after the read: merged while bypass is enabled.
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 2'b01, 4'd5, 4'h0);
    cycle(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 2'b00, 4'h0, 4'h0);
    idle();
    check("byp_t1", 64'(samp_rdata[0]), 64'(BYP != 0 ? 32'hDEADBEEF : INIT));

    // Write READ_LATENCY cycles after the read: never visible.
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 2'b01, 4'd6, 4'h0);
    idle();
    cycle(1'b1, 4'd6, 32'hDEADBEEF, 4'hF, 2'b00, 4'h0, 4'h0);
    check("byp_t2", 64'(samp_rdata[0]), 64'(INIT));

    // Same-cycle write.
    cycle(1'b1, 4'd8, 32'hDEADBEEF, 4'hF, 2'b01, 4'd8, 4'h0);
    idle(); idle();
    check("byp_same", 64'(samp_rdata[0]), 64'(BYP != 0 ? 32'hDEADBEEF : INIT));

    // All-zero byte enables leave the entry alone (every 4-bit address is in range here).
    cycle(1'b1, 4'd7, 32'h12345678, 4'b0000, 2'b00, 4'h0, 4'h0);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 2'b10, 4'h0, 4'd7);
    idle(); idle();
    check("wbe_zero", 64'(samp_rdata[1]), 64'(INIT));

    // Two fixed readers while the writer hammers both addresses.
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom), 4'($urandom_range(1, 2)), $urandom, 4'($urandom), 2'b11, 4'd1, 4'd2);

    // Fully random traffic on both ports.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 4'($urandom), $urandom, 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    idle(); idle();

    // Reset with reads in flight, then confirm the array was refilled.
    cycle(1'b1, 4'd3, 32'h0BADF00D, 4'hF, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 32'h0, 4'h0, 2'b11, 4'd3, 4'd3);
    do_reset();
    run_init();
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 2'b01, 4'd3, 4'h0);
    idle(); idle();
    check("reinit", 64'(samp_rdata[0]), 64'(INIT));
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
